comma_aligner: RTL and testbench
================================

COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 Parameter VERIFY_CNT, default 2: in-phase commas required after first acquisition before lock.
REQ-002 Parameter LOSS_CNT, default 3: misaligned commas in LOCKED, with no in-phase comma between them, that force re-hunt.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  din carries a new raw word this cycle.
REQ-006 din  input  10  raw deserialized bits, unaligned; din[9] is the earliest-received bit.
REQ-007 dout  output  10  aligned 10b symbol; dout[9] = bit a, dout[0] = bit j; feeds the 8b10b decoder din.
REQ-008 dout_vld  output  1  dout holds a new aligned symbol; drives the decoder en.
REQ-009 comma_det  output  1  current dout is an in-phase comma symbol.
REQ-010 locked  output  1  FSM in LOCKED.
REQ-011 align_ofs  output  4  current bit offset, 0..9.

Function
REQ-012 Window: on each en, prev <= cur and cur <= din; window W[19:0] = {prev, cur} after the update.
REQ-013 Candidate at offset k (0..9) SHALL be W[19-k:10-k].
REQ-014 Comma at offset k: W[19-k:13-k] equals 0011111 or 1100000.
REQ-015 Comma search SHALL run only when en=1 and at least one earlier en has occurred since reset (prime flag); the first en after reset never detects.
REQ-016 When more than one offset matches in HUNT, the lowest k wins.
REQ-017 FSM states: HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-018 HUNT: comma at k -> latch align_ofs=k, vcnt=0, go VERIFY.
REQ-019 VERIFY, in-phase comma (offset = align_ofs): vcnt+1; when vcnt reaches VERIFY_CNT -> LOCKED, mcnt=0.
REQ-020 VERIFY, comma at any other offset: go HUNT, vcnt=0; that same comma SHALL NOT re-acquire in this cycle.
REQ-021 LOCKED, misaligned comma: mcnt+1; mcnt reaching LOSS_CNT -> HUNT.
REQ-022 LOCKED, in-phase comma: mcnt=0.
REQ-023 align_ofs SHALL be held in VERIFY and LOCKED and change only on a HUNT acquisition.
REQ-024 Output register, updated on every en cycle that is in VERIFY or LOCKED, or that is an acquisition cycle: dout <= W[19-ofs:10-ofs], using the newly latched offset on acquisition; dout_vld <= 1.
REQ-025 Latency: the symbol whose last bit arrives with en at cycle N appears on dout with dout_vld=1 at cycle N+1.
REQ-026 dout_vld SHALL be 0 in any cycle not following such an en, including all HUNT cycles without acquisition; dout holds its last value.
REQ-027 comma_det SHALL be registered alongside dout and is 1 only for in-phase commas.
REQ-028 en=0: window, FSM, counters and dout hold; dout_vld, comma_det = 0 next cycle.
REQ-029 Transition back to HUNT SHALL drop dout_vld and locked on the next cycle.

Reset
REQ-030 While rst=0, asynchronously:
  - prev=cur=0, prime=0
  - state=HUNT, vcnt=mcnt=0
  - dout=0, dout_vld=0, comma_det=0, locked=0, align_ofs=0
REQ-031 Deassertion mid-stream: resume in HUNT at the next edge; the first en after deassertion only primes the window.

Verification
REQ-032 Offset 0: stream K28.5- 0011111010, D21.5 1010101010 repeated, en=1 -> align_ofs=0.
  - dout_vld from the 2nd en
  - comma_det on each K28.5
  - locked after the 3rd comma
REQ-033 Same stream delayed 3 bits -> align_ofs=3; dout shows exact 0011111010 / 1010101010; locked after 3 commas.
REQ-034 Locked at offset 0, then 1 bit slip inserted -> 3 misaligned commas -> locked=0, HUNT; re-acquires align_ofs=1 and relocks after 3 more commas.
REQ-035 VERIFY at ofs 0, then K28.5+ 1100000101 presented at offset 5 -> HUNT, dout_vld=0; that comma is not acquired.
REQ-036 en toggled 1/0 every cycle on a locked stream -> dout_vld pulses once per en, one cycle late; dout unchanged during en=0.
REQ-037 rst asserted during LOCKED -> all outputs 0 immediately (async); after release, the first en produces no dout_vld.

Source files
------------

// File: rtl/comma_aligner.sv
// 10b comma aligner: finds the K28.x comma bit offset in an unaligned 10-bit stream,
// verifies it, holds lock with loss hysteresis, and emits aligned symbols to the decoder.
module comma_aligner #(
  parameter int unsigned VERIFY_CNT = 2,
  parameter int unsigned LOSS_CNT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] din,
  output logic [9:0] dout,
  output logic       dout_vld,
  output logic       comma_det,
  output logic       locked,
  output logic [3:0] align_ofs
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]  state, state_n;
  logic [9:0]  cur;
  logic        prime;
  logic [7:0]  vcnt, vcnt_n;
  logic [7:0]  mcnt, mcnt_n;
  logic [19:0] win;
  logic [9:0]  comma_at;
  logic        hit;
  logic [3:0]  hit_ofs;
  logic        in_phase;
  logic        off_phase;
  logic        acq;
  logic        upd;
  logic [3:0]  ofs_sel;
  logic [9:0]  dout_n;
  logic        det_n;

  // Window after this cycle's update; the older word is the current cur register.
  assign win = {cur, din};

  always_comb begin
    comma_at  = '0;
    hit       = 1'b0;
    hit_ofs   = '0;
    in_phase  = 1'b0;
    off_phase = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (en && prime &&
          (win[19-k -: 7] == 7'b0011111 || win[19-k -: 7] == 7'b1100000)) begin
        comma_at[k] = 1'b1;
        if (!hit) begin
          hit     = 1'b1;
          hit_ofs = 4'(k);
        end
        if (align_ofs == 4'(k)) in_phase = 1'b1;
        else                    off_phase = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    vcnt_n  = vcnt;
    mcnt_n  = mcnt;
    acq     = 1'b0;
    case (state)
      HUNT: begin
        if (hit) begin
          acq     = 1'b1;
          state_n = VERIFY;
          vcnt_n  = '0;
        end
      end
      VERIFY: begin
        // An in-phase hit outranks a coincident off-phase pattern.
        if (in_phase) begin
          if (vcnt == 8'(VERIFY_CNT - 1)) begin
            state_n = LOCKED;
            vcnt_n  = '0;
            mcnt_n  = '0;
          end else begin
            vcnt_n = vcnt + 8'd1;
          end
        end else if (off_phase) begin
          state_n = HUNT;
          vcnt_n  = '0;
        end
      end
      LOCKED: begin
        if (in_phase) begin
          mcnt_n = '0;
        end else if (off_phase) begin
          if (mcnt == 8'(LOSS_CNT - 1)) begin
            state_n = HUNT;
            mcnt_n  = '0;
          end else begin
            mcnt_n = mcnt + 8'd1;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Output uses the freshly acquired offset on the acquisition cycle itself.
  always_comb begin
    ofs_sel = acq ? hit_ofs : align_ofs;
    upd     = en && (state_n != HUNT);
    dout_n  = '0;
    det_n   = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (ofs_sel == 4'(k)) begin
        dout_n = win[19-k -: 10];
        det_n  = comma_at[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= '0;
      prime     <= 1'b0;
      state     <= HUNT;
      vcnt      <= '0;
      mcnt      <= '0;
      align_ofs <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      comma_det <= 1'b0;
    end else begin
      if (en) begin
        cur   <= din;
        prime <= 1'b1;
      end
      state <= state_n;
      vcnt  <= vcnt_n;
      mcnt  <= mcnt_n;
      if (acq) align_ofs <= hit_ofs;
      dout_vld  <= upd;
      comma_det <= upd && det_n;
      if (upd) dout <= dout_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: offset acquisition, priority, slip/re-hunt,
// verify abort, en gating and asynchronous reset, against hand-computed outputs.
module tb_comma_aligner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] din;
  logic [9:0] dout;
  logic       dout_vld;
  logic       comma_det;
  logic       locked;
  logic [3:0] align_ofs;

  always #5 clk = ~clk;

  comma_aligner #(.VERIFY_CNT(2), .LOSS_CNT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout), .dout_vld(dout_vld), .comma_det(comma_det),
    .locked(locked), .align_ofs(align_ofs)
  );

  localparam logic [9:0] K = 10'b0011111010;  // K28.5-
  localparam logic [9:0] D = 10'b1010101010;  // D21.5
  localparam logic [9:0] O = 10'b0001111101;  // K straddling a 1-bit slip
  localparam logic [9:0] E = 10'b0101010101;  // D straddling a 1-bit slip

  int nvec  = 0;
  int nfail = 0;
  bit bq[$];

  // Packed view {locked, dout_vld, comma_det, align_ofs, dout}
  function automatic logic [16:0] e(input bit l, input bit v, input bit c,
                                    input int unsigned o, input logic [9:0] d);
    return {l, v, c, 4'(o), d};
  endfunction

  function automatic logic [16:0] obs();
    return {locked, dout_vld, comma_det, align_ofs, dout};
  endfunction

  task automatic push_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
  endtask

  task automatic pop_word(output logic [9:0] w);
    for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
  endtask

  task automatic step(input logic en_in, input logic [9:0] d);
    @(negedge clk);
    en  = en_in;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bq.delete();
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst = 1'b0;
    en  = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    got = obs();
    nvec++;
    if (got !== 17'd0) begin
      nfail++;
      $display("FAIL reset: got %b expected %b", got, 17'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_align(input int unsigned nfill, input string name);
    logic [16:0] ev [7];
    logic [16:0] got;
    logic [9:0]  w;
    do_reset();
    for (int unsigned i = 0; i < nfill; i++) bq.push_back(i % 2 == 0);
    repeat (5) begin
      push_sym(K);
      push_sym(D);
    end
    ev = '{e(0,0,0,0,0),     e(0,1,1,nfill,K), e(0,1,0,nfill,D), e(0,1,1,nfill,K),
           e(0,1,0,nfill,D), e(1,1,1,nfill,K), e(1,1,0,nfill,D)};
    for (int unsigned i = 0; i < 7; i++) begin
      pop_word(w);
      step(1'b1, w);
      got = obs();
      nvec++;
      if (got !== ev[i]) begin
        nfail++;
        $display("FAIL %s step %0d: got lock/vld/cd/ofs/dout=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                 name, i, got[16], got[15], got[14], got[13:10], got[9:0],
                 ev[i][16], ev[i][15], ev[i][14], ev[i][13:10], ev[i][9:0]);
      end
    end
  endtask

  task automatic test_priority();
    logic [9:0]  wv [2];
    logic [16:0] ev [2];
    logic [16:0] got;
    do_reset();
    // Commas at offsets 2 and 7 in the same window
    wv = '{10'b1000111110, 10'b0000101010};
    ev = '{e(0,0,0,0,0), e(0,1,1,2,10'b0011111000)};
    for (int unsigned i = 0; i < 2; i++) begin
      step(1'b1, wv[i]);
      got = obs();
      nvec++;
      if (got !== ev[i]) begin
        nfail++;
        $display("FAIL priority step %0d: got lock/vld/cd/ofs/dout=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                 i, got[16], got[15], got[14], got[13:10], got[9:0],
                 ev[i][16], ev[i][15], ev[i][14], ev[i][13:10], ev[i][9:0]);
      end
    end
  endtask

  task automatic test_slip();
    logic [16:0] ev [18];
    logic [16:0] got;
    logic [9:0]  w;
    do_reset();
    repeat (3) begin
      push_sym(K);
      push_sym(D);
    end
    bq.push_back(1'b0);
    repeat (7) begin
      push_sym(K);
      push_sym(D);
    end
    ev = '{e(0,0,0,0,0), e(0,1,1,0,K), e(0,1,0,0,D), e(0,1,1,0,K), e(0,1,0,0,D),
           e(1,1,1,0,K), e(1,1,0,0,D), e(1,1,0,0,O), e(1,1,0,0,E), e(1,1,0,0,O),
           e(1,1,0,0,E), e(0,0,0,0,E), e(0,0,0,0,E), e(0,1,1,1,K), e(0,1,0,1,D),
           e(0,1,1,1,K), e(0,1,0,1,D), e(1,1,1,1,K)};
    for (int unsigned i = 0; i < 18; i++) begin
      pop_word(w);
      step(1'b1, w);
      got = obs();
      nvec++;
      if (got !== ev[i]) begin
        nfail++;
        $display("FAIL slip step %0d: got lock/vld/cd/ofs/dout=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                 i, got[16], got[15], got[14], got[13:10], got[9:0],
                 ev[i][16], ev[i][15], ev[i][14], ev[i][13:10], ev[i][9:0]);
      end
    end
  endtask

  task automatic test_verify_break();
    logic [9:0]  wv [5];
    logic [16:0] ev [5];
    logic [16:0] got;
    do_reset();
    // Words 3/4 carry K28.5+ 1100000101 at offset 5
    wv = '{K, D, 10'b1010111000, 10'b0010110101, D};
    ev = '{e(0,0,0,0,0), e(0,1,1,0,K), e(0,1,0,0,D), e(0,0,0,0,D), e(0,0,0,0,D)};
    for (int unsigned i = 0; i < 5; i++) begin
      step(1'b1, wv[i]);
      got = obs();
      nvec++;
      if (got !== ev[i]) begin
        nfail++;
        $display("FAIL verify_break step %0d: got lock/vld/cd/ofs/dout=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                 i, got[16], got[15], got[14], got[13:10], got[9:0],
                 ev[i][16], ev[i][15], ev[i][14], ev[i][13:10], ev[i][9:0]);
      end
    end
  endtask

  task automatic test_en_toggle();
    logic        env [11];
    logic [9:0]  wv  [11];
    logic [16:0] ev  [11];
    logic [16:0] got;
    do_reset();
    env = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0};
    wv  = '{K, D, K, D, K, D, 10'b1100000111, K, 10'b0011111000, D, 10'h3FF};
    ev  = '{e(0,0,0,0,0), e(0,1,1,0,K), e(0,1,0,0,D), e(0,1,1,0,K), e(0,1,0,0,D),
            e(1,1,1,0,K), e(1,0,0,0,K), e(1,1,0,0,D), e(1,0,0,0,D), e(1,1,1,0,K),
            e(1,0,0,0,K)};
    for (int unsigned i = 0; i < 11; i++) begin
      step(env[i], wv[i]);
      got = obs();
      nvec++;
      if (got !== ev[i]) begin
        nfail++;
        $display("FAIL en_toggle step %0d: got lock/vld/cd/ofs/dout=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                 i, got[16], got[15], got[14], got[13:10], got[9:0],
                 ev[i][16], ev[i][15], ev[i][14], ev[i][13:10], ev[i][9:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0]  wv [8];
    logic [16:0] ev [9];
    logic [16:0] got;
    do_reset();
    wv = '{K, D, K, D, K, D, K, D};
    ev = '{e(0,0,0,0,0), e(0,1,1,0,K), e(0,1,0,0,D), e(0,1,1,0,K), e(0,1,0,0,D),
           e(1,1,1,0,K), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,1,0,K)};
    for (int unsigned i = 0; i < 9; i++) begin
      if (i == 6) begin
        // Mid-cycle assertion, sampled before any further clock edge
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        step(1'b1, wv[(i < 6) ? i : i - 1]);
      end
      got = obs();
      nvec++;
      if (got !== ev[i]) begin
        nfail++;
        $display("FAIL async_reset step %0d: got lock/vld/cd/ofs/dout=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                 i, got[16], got[15], got[14], got[13:10], got[9:0],
                 ev[i][16], ev[i][15], ev[i][14], ev[i][13:10], ev[i][9:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_align(0, "align_ofs0");
    test_align(3, "align_ofs3");
    test_priority();
    test_slip();
    test_verify_break();
    test_en_toggle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
